des_dec_keysched: RTL and testbench
===================================

# des_dec_keysched

Iterative DES key-schedule generator for the decrypt direction. It accepts a 64-bit DES key over a valid/ready handshake and streams the 16 round subkeys in reverse order, K16 first and K1 last, one subkey per accepted transfer. It sits beside the f(R,K) datapath (E-expansion, the S-box lookups, P-permutation) and feeds the round engine. An optional build adds the forward (encrypt) ordering.

## Interface
Parameters: none. Tables and schedules are fixed constants in `des_pkg`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  `key` is presented.
- `key`  in  64  DES key, FIPS bit 1 = `key[63]`. Parity bits (8,16,…,64) are ignored.
- `key_ready`  out  1  block is IDLE and will accept a key.
- `sk_valid`  out  1  `sk` holds a valid subkey.
- `sk_ready`  in  1  round engine consumes `sk` this cycle.
- `sk`  out  48  current subkey, FIPS bit 1 = `sk[47]`.
- `sk_round`  out  4  DES round number of `sk`, minus 1 (K16 → 15).
- `sk_last`  out  1  high with the final subkey of the sequence.
- `done`  out  1  one-cycle pulse after the final subkey transfers.
- `enc`  in  1  only with `DES_ENC_DIR_EN`: 1 = forward order (K1..K16).

## Operation
- State machine: IDLE, RUN.
- IDLE:
  - `key_ready`=1 and `sk_valid`=0.
  - On `key_valid & key_ready`, register CD = PC1(`key`) (C = bits 1–28, D = bits 29–56).
  - Register `sk` = PC2(CD) and `sk_round`=15, then go to RUN.
- RUN:
  - `key_ready`=0 and `sk_valid`=1. `key_valid` is ignored.
  - On `sk_valid & sk_ready`: rotate C and D right by the decrypt shift for the next subkey, register `sk` = PC2(rotated CD), and decrement `sk_round`.
  - Decrypt right-shift schedule, applied before producing subkeys in order K16..K1: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. K16 uses the unrotated PC1 output, since the 28 total encrypt shifts restore C0/D0.
  - `sk_last`=1 when `sk_round`==0.
  - A transfer with `sk_last`=1 returns the block to IDLE, pulses `done` next cycle, and drops `sk_valid` next cycle.
- When `sk_ready`=0, `sk`, `sk_round` and CD hold unchanged.
- Rotations are on 28-bit fields with wrap-around. Arithmetic is pure bit wiring, with no adders except the 4-bit round counter.

## Timing
- Reset values: `key_ready`=1, `sk_valid`=0, `sk`=0, `sk_round`=0, `sk_last`=0, `done`=0, CD=0, state IDLE.
- Key accepted in cycle N gives `sk_valid`=1 with K16 in cycle N+1.
- With `sk_ready` held high, the 16 subkeys occupy cycles N+1..N+16.
- `done`=1 in cycle N+17 together with `key_ready`=1. A new key may be accepted in N+17.
- `done` is never asserted while `sk_valid`=1.
- `reset` asserted mid-RUN returns to reset values in the next cycle. The partial sequence is abandoned and `done` does not pulse.
- `reset` takes priority over every handshake in the same cycle.
- All outputs are registered. There is no combinational path from `sk_ready` or `key_valid` to any output.

## Configuration
- `DES_ENC_DIR_EN` defined:
  - Adds the `enc` port, sampled at key acceptance and held for the sequence.
  - `enc`=1 gives left rotations with schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, applied before each subkey K1..K16.
  - In forward order the first `sk` = PC2(rotl1(PC1(key))), `sk_round` counts 0→15, and `sk_last` is set at 15.
  - `enc`=0 behaves exactly as the decrypt mode.
- Not defined: no `enc` port; decrypt order only.

## Structure
- `des_pkg` holds:
  - PC1 index array (56 entries) and PC2 index array (48 entries).
  - Decrypt and encrypt shift schedules (16×2-bit).
  - State enum {IDLE, RUN}.
  - Width localparams KEY_W=64, CD_W=56, SK_W=48.
- One sub-module: `des_pc2`, combinational 56→48 permutation, instantiated once on the next-CD path.
- PC1 is applied inline.

## Test plan
- Reset: hold `reset` for 2 cycles, then check all outputs at their reset values and `key_ready`=1.
- Decrypt order: load key 0x133457799BBCDFF1 with `sk_ready`=1.
  - First `sk`=0xCB3D8B0E17F5 with `sk_round`=15.
  - Last `sk`=0x1B02EFFC7072 with `sk_round`=0 and `sk_last`=1.
  - `done` pulses at N+17.
- Backpressure: same key, toggle `sk_ready` pseudo-randomly. Require the same 16-subkey sequence, with `sk` stable while stalled.
- Ignored load: pulse `key_valid` with a different key during RUN. Require `key_ready`=0 and the sequence unchanged.
- Reset mid-stream: assert `reset` after the 5th transfer. Require reset values next cycle, no `done`, then a clean reload reproducing K16 first.
- With `DES_ENC_DIR_EN`, same key and `enc`=1. Require first `sk`=0x1B02EFFC7072 with `sk_round`=0, and last `sk`=0xCB3D8B0E17F5 with `sk_round`=15.

Source files
------------

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule tables, shift schedules, widths and state type
package des_pkg;

    localparam int KEY_W = 64;
    localparam int CD_W  = 56;
    localparam int SK_W  = 48;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // FIPS 1-based source bit numbers, listed from output bit 1 onwards
    localparam int PC1_TAB [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [SK_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Indexed by position in the emitted sequence (K16..K1 or K1..K16)
    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // MSB is FIPS bit 1, so a left rotation moves the MSB to the LSB
    function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n,
                                          input logic left);
        logic [27:0] r;
        r = x;
        if (left) begin
            case (n)
                2'd1:    r = {x[26:0], x[27]};
                2'd2:    r = {x[25:0], x[27:26]};
                default: r = x;
            endcase
        end else begin
            case (n)
                2'd1:    r = {x[0], x[27:1]};
                2'd2:    r = {x[1:0], x[27:2]};
                default: r = x;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/des_dec_keysched_if.sv
// rtl/des_dec_keysched_if.sv - key load and subkey stream bus; enc only with DES_ENC_DIR_EN
interface des_dec_keysched_if;

    logic                       key_valid;
    logic [des_pkg::KEY_W-1:0]  key;
    logic                       key_ready;
    logic                       sk_valid;
    logic                       sk_ready;
    logic [des_pkg::SK_W-1:0]   sk;
    logic [3:0]                 sk_round;
    logic                       sk_last;
    logic                       done;

`ifdef DES_ENC_DIR_EN
    logic                       enc;

    modport master (
        output key_valid, key, sk_ready, enc,
        input  key_ready, sk_valid, sk, sk_round, sk_last, done
    );

    modport slave (
        input  key_valid, key, sk_ready, enc,
        output key_ready, sk_valid, sk, sk_round, sk_last, done
    );
`else
    modport master (
        output key_valid, key, sk_ready,
        input  key_ready, sk_valid, sk, sk_round, sk_last, done
    );

    modport slave (
        input  key_valid, key, sk_ready,
        output key_ready, sk_valid, sk, sk_round, sk_last, done
    );
`endif

endinterface

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational DES permuted choice 2 (56 to 48 bits)
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0] cd,
    output logic [SK_W-1:0] sk
);

    always_comb begin
        sk = '0;
        for (int j = 0; j < SK_W; j++) begin
            sk[SK_W-1-j] = cd[CD_W-PC2_TAB[j]];
        end
    end

endmodule

// File: rtl/des_dec_keysched.sv
// rtl/des_dec_keysched.sv - iterative DES subkey generator, K16..K1; K1..K16 option with DES_ENC_DIR_EN
module des_dec_keysched
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    des_dec_keysched_if.slave bus
);

    state_t          state, state_n;
    logic [CD_W-1:0] cd, cd_pc1, cd_base, cd_n;
    logic [SK_W-1:0] sk_q, sk_n;
    logic [3:0]      round_q, round_n, idx;
    logic [1:0]      shift;
    logic            last_q, last_n, done_q, done_n;
    logic            load, update, enc_sel;

    assign load = (state == IDLE) && bus.key_valid;

`ifdef DES_ENC_DIR_EN
    logic enc_q;

    assign enc_sel = (state == IDLE) ? bus.enc : enc_q;

    always_ff @(posedge clk) begin
        if (reset)     enc_q <= 1'b0;
        else if (load) enc_q <= bus.enc;
    end
`else
    assign enc_sel = 1'b0;
`endif

    always_comb begin
        cd_pc1 = '0;
        for (int j = 0; j < CD_W; j++) begin
            cd_pc1[CD_W-1-j] = bus.key[KEY_W-PC1_TAB[j]];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        update  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    state_n = RUN;
                    update  = 1'b1;
                end
            end
            RUN: begin
                if (bus.sk_ready) begin
                    if (last_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        update = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Decrypt walks the sequence backwards, so its schedule index is 15 - round
    always_comb begin
        cd_base = load ? cd_pc1 : cd;
        if (load)         round_n = enc_sel ? 4'd0 : 4'd15;
        else if (enc_sel) round_n = round_q + 4'd1;
        else              round_n = round_q - 4'd1;
        idx     = enc_sel ? round_n : ~round_n;
        shift   = enc_sel ? ENC_SHIFT[idx] : DEC_SHIFT[idx];
        cd_n    = {rot28(cd_base[55:28], shift, enc_sel), rot28(cd_base[27:0], shift, enc_sel)};
        last_n  = enc_sel ? (round_n == 4'd15) : (round_n == 4'd0);
    end

    des_pc2 u_pc2 (
        .cd (cd_n),
        .sk (sk_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cd      <= '0;
            sk_q    <= '0;
            round_q <= 4'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_n;
            if (update) begin
                cd      <= cd_n;
                sk_q    <= sk_n;
                round_q <= round_n;
                last_q  <= last_n;
            end
        end
    end

    assign bus.key_ready = (state == IDLE);
    assign bus.sk_valid  = (state == RUN);
    assign bus.sk        = sk_q;
    assign bus.sk_round  = round_q;
    assign bus.sk_last   = last_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_des_dec_keysched.sv
// tb/tb_des_dec_keysched.sv - randomized self-checking bench against a forward key-schedule model
module tb_des_dec_keysched;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    des_dec_keysched_if bus ();

    des_dec_keysched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int TB_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int TB_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] FIPS_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] FIPS_K16 = 48'hCB3D8B0E17F5;

    logic [47:0] ref_sk [16];
    int checks;
    int errors;

    // Textbook forward schedule: cumulative left shifts, ref_sk[n-1] holds Kn
    task automatic build_ref(input logic [63:0] k);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] s;
        for (int j = 0; j < 56; j++) cd[55-j] = k[64-TB_PC1[j]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int t = 0; t < LSHIFT[r]; t++) begin
                c = (c << 1) | (c >> 27);
                d = (d << 1) | (d >> 27);
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) s[47-j] = cd[56-TB_PC2[j]];
            ref_sk[r] = s;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] k, input logic enc_mode);
        bus.key       = k;
        bus.key_valid = 1'b1;
`ifdef DES_ENC_DIR_EN
        bus.enc       = enc_mode;
`else
        if (enc_mode) $display("note: forward order requested in a decrypt-only build");
`endif
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.sk_ready  = 1'b0;
`ifdef DES_ENC_DIR_EN
        bus.enc       = 1'b0;
`endif
        tick();
        tick();
        checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", bus.key_ready); end
        checks++; if (bus.sk_valid !== 1'b0) begin errors++; $display("FAIL reset_sk_valid: got %b expected 0", bus.sk_valid); end
        checks++; if (bus.sk !== 48'h0) begin errors++; $display("FAIL reset_sk: got %h expected 0", bus.sk); end
        checks++; if (bus.sk_round !== 4'd0) begin errors++; $display("FAIL reset_sk_round: got %0d expected 0", bus.sk_round); end
        checks++; if (bus.sk_last !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_last_done: got last=%b done=%b expected 0 0", bus.sk_last, bus.done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_decrypt();
        build_ref(FIPS_KEY);
        bus.sk_ready = 1'b1;
        load_key(FIPS_KEY, 1'b0);
        checks++; if (bus.sk !== FIPS_K16 || bus.sk_round !== 4'd15) begin errors++; $display("FAIL dec_first: got sk=%h round=%0d expected sk=%h round=15", bus.sk, bus.sk_round, FIPS_K16); end
        checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL dec_key_ready: got %b expected 0", bus.key_ready); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.sk_valid !== 1'b1 || bus.sk !== ref_sk[15-i] || bus.sk_round !== 4'(15 - i) ||
                bus.sk_last !== (i == 15) || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL dec_seq[%0d]: got v=%b sk=%h round=%0d last=%b done=%b expected v=1 sk=%h round=%0d last=%b done=0",
                         i, bus.sk_valid, bus.sk, bus.sk_round, bus.sk_last, bus.done, ref_sk[15-i], 15 - i, i == 15);
            end
            if (i == 15) begin
                checks++; if (bus.sk !== FIPS_K1 || bus.sk_round !== 4'd0 || bus.sk_last !== 1'b1) begin errors++; $display("FAIL dec_last: got sk=%h round=%0d last=%b expected sk=%h round=0 last=1", bus.sk, bus.sk_round, bus.sk_last, FIPS_K1); end
            end
            tick();
        end
        checks++; if (bus.done !== 1'b1 || bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0) begin errors++; $display("FAIL dec_done: got done=%b ready=%b valid=%b expected 1 1 0", bus.done, bus.key_ready, bus.sk_valid); end
        tick();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dec_done_pulse: got %b expected 0", bus.done); end
        bus.sk_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [63:0] k;
        logic        rdy;
        int          n;
        int          cyc;
        for (int t = 0; t < 3; t++) begin
            k = (t == 0) ? FIPS_KEY : {$urandom, $urandom};
            build_ref(k);
            bus.sk_ready = 1'b0;
            load_key(k, 1'b0);
            n   = 0;
            cyc = 0;
            while (n < 16 && cyc < 400) begin
                rdy          = 1'($urandom_range(0, 1));
                bus.sk_ready = rdy;
                checks++;
                if (bus.sk_valid !== 1'b1 || bus.sk !== ref_sk[15-n] || bus.sk_round !== 4'(15 - n) ||
                    bus.sk_last !== (n == 15) || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_seq[%0d] key=%h: got v=%b sk=%h round=%0d last=%b done=%b expected sk=%h round=%0d",
                             n, k, bus.sk_valid, bus.sk, bus.sk_round, bus.sk_last, bus.done, ref_sk[15-n], 15 - n);
                end
                tick();
                if (rdy) n++;
                cyc++;
            end
            checks++; if (n != 16 || bus.done !== 1'b1) begin errors++; $display("FAIL bp_done key=%h: got transfers=%0d done=%b expected 16 1", k, n, bus.done); end
            bus.sk_ready = 1'b0;
            tick();
        end
    endtask

    task automatic test_ignored_load();
        logic [63:0] ka, kb;
        ka = {$urandom, $urandom};
        kb = ~ka;
        build_ref(ka);
        bus.sk_ready = 1'b1;
        load_key(ka, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                bus.key       = kb;
                bus.key_valid = 1'b1;
            end
            if (i == 6) bus.key_valid = 1'b0;
            if (i >= 3 && i < 6) begin
                checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL ign_key_ready[%0d]: got %b expected 0", i, bus.key_ready); end
            end
            checks++;
            if (bus.sk !== ref_sk[15-i] || bus.sk_round !== 4'(15 - i)) begin
                errors++;
                $display("FAIL ign_seq[%0d]: got sk=%h round=%0d expected sk=%h round=%0d", i, bus.sk, bus.sk_round, ref_sk[15-i], 15 - i);
            end
            tick();
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", bus.done); end
        bus.sk_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        logic [63:0] k;
        k = {$urandom, $urandom};
        build_ref(k);
        bus.sk_ready = 1'b1;
        load_key(k, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checks++; if (bus.sk !== ref_sk[10] || bus.sk_round !== 4'd10) begin errors++; $display("FAIL mid_pre: got sk=%h round=%0d expected sk=%h round=10", bus.sk, bus.sk_round, ref_sk[10]); end
        reset         = 1'b1;
        bus.key_valid = 1'b1;
        tick();
        reset         = 1'b0;
        bus.key_valid = 1'b0;
        checks++;
        if (bus.key_ready !== 1'b1 || bus.sk_valid !== 1'b0 || bus.sk !== 48'h0 || bus.sk_round !== 4'd0 ||
            bus.sk_last !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got ready=%b valid=%b sk=%h round=%0d last=%b done=%b expected 1 0 0 0 0 0",
                     bus.key_ready, bus.sk_valid, bus.sk, bus.sk_round, bus.sk_last, bus.done);
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.done !== 1'b0 || bus.sk_valid !== 1'b0) begin errors++; $display("FAIL mid_quiet[%0d]: got done=%b valid=%b expected 0 0", i, bus.done, bus.sk_valid); end
            tick();
        end
        load_key(k, 1'b0);
        checks++; if (bus.sk !== ref_sk[15] || bus.sk_round !== 4'd15) begin errors++; $display("FAIL mid_reload: got sk=%h round=%0d expected sk=%h round=15", bus.sk, bus.sk_round, ref_sk[15]); end
        for (int i = 0; i < 16; i++) tick();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL mid_reload_done: got %b expected 1", bus.done); end
        bus.sk_ready = 1'b0;
        tick();
    endtask

`ifdef DES_ENC_DIR_EN
    task automatic test_encrypt();
        build_ref(FIPS_KEY);
        bus.sk_ready = 1'b1;
        load_key(FIPS_KEY, 1'b1);
        bus.enc = 1'b0;
        checks++; if (bus.sk !== FIPS_K1 || bus.sk_round !== 4'd0) begin errors++; $display("FAIL enc_first: got sk=%h round=%0d expected sk=%h round=0", bus.sk, bus.sk_round, FIPS_K1); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.sk_valid !== 1'b1 || bus.sk !== ref_sk[i] || bus.sk_round !== 4'(i) || bus.sk_last !== (i == 15)) begin
                errors++;
                $display("FAIL enc_seq[%0d]: got v=%b sk=%h round=%0d last=%b expected sk=%h round=%0d",
                         i, bus.sk_valid, bus.sk, bus.sk_round, bus.sk_last, ref_sk[i], i);
            end
            if (i == 15) begin
                checks++; if (bus.sk !== FIPS_K16 || bus.sk_round !== 4'd15) begin errors++; $display("FAIL enc_last: got sk=%h round=%0d expected sk=%h round=15", bus.sk, bus.sk_round, FIPS_K16); end
            end
            tick();
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL enc_done: got %b expected 1", bus.done); end
        bus.sk_ready = 1'b0;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decrypt();
        test_backpressure();
        test_ignored_load();
        test_reset_midstream();
`ifdef DES_ENC_DIR_EN
        test_encrypt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
